// File: rtl/dist_sq_to_float.sv
// Squared distance of two signed 3-D points, converted to an IEEE-754 single for the sqrt unit.
// Build option: define DIST_SQ_RNE_EN for round-to-nearest-even; otherwise dropped bits truncate.
module dist_sq_to_float #(
  parameter int COORD_W = 16,
  parameter int ACC_W   = 2*COORD_W+2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COORD_W-1:0] ax,
  input  logic [COORD_W-1:0] ay,
  input  logic [COORD_W-1:0] az,
  input  logic [COORD_W-1:0] bx,
  input  logic [COORD_W-1:0] by,
  input  logic [COORD_W-1:0] bz,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        n,
  output logic               zero
);

  localparam int DW = COORD_W+1;
  localparam int PW = 2*DW;
  localparam int PB = $clog2(ACC_W);
  localparam int NW = (ACC_W > 26) ? ACC_W : 26;
  localparam int NB = NW-1;

  typedef enum logic [2:0] {IDLE, SUB, MUL_X, MUL_Y, MUL_Z, CONV, OUT} state_t;

  state_t                    state_q, state_d;
  logic signed [COORD_W-1:0] ax_q, ay_q, az_q, bx_q, by_q, bz_q;
  logic signed [COORD_W-1:0] ax_d, ay_d, az_d, bx_d, by_d, bz_d;
  logic signed [DW-1:0]      dx_q, dy_q, dz_q, dx_d, dy_d, dz_d;
  logic [ACC_W-1:0]          acc_q, acc_d;
  logic [31:0]               n_q, n_d;
  logic                      zero_q, zero_d;

  logic signed [DW-1:0]      mul_op;
  logic signed [PW-1:0]      op_ext, sq;
  logic [PB-1:0]             lead;
  int                        sh;
  logic [NB-1:0]             below;
  logic [7:0]                exp_raw, exp_f;
  logic [22:0]               frac_f;
`ifdef DIST_SQ_RNE_EN
  logic [22:0]               mant;
  logic                      guard, sticky;
  logic [23:0]               rnd;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign n         = n_q;
  assign zero      = zero_q;

  // One multiplier shared across the three square cycles.
  always_comb begin
    mul_op = dx_q;
    case (state_q)
      MUL_Y:   mul_op = dy_q;
      MUL_Z:   mul_op = dz_q;
      default: mul_op = dx_q;
    endcase
    op_ext = PW'(mul_op);
    sq     = op_ext * op_ext;
  end

  // Normalise: "below" holds the bits under the leading one, MSB-aligned.
  always_comb begin
    lead = '0;
    for (int i = 0; i < ACC_W; i++)
      if (acc_q[i]) lead = PB'(i);
    sh      = NW - 1 - int'(lead);
    below   = NB'(NW'(acc_q) << sh);
    exp_raw = 8'(127 + int'(lead));
`ifdef DIST_SQ_RNE_EN
    mant   = below[NB-1 -: 23];
    guard  = below[NB-24];
    sticky = |below[NB-25:0];
    rnd    = {1'b0, mant} + 24'(guard & (sticky | mant[0]));
    frac_f = rnd[22:0];
    exp_f  = exp_raw + 8'(rnd[23]);
`else
    frac_f = 23'(below >> (NB-23));
    exp_f  = exp_raw;
`endif
  end

  always_comb begin
    state_d = state_q;
    ax_d = ax_q; ay_d = ay_q; az_d = az_q;
    bx_d = bx_q; by_d = by_q; bz_d = bz_q;
    dx_d = dx_q; dy_d = dy_q; dz_d = dz_q;
    acc_d  = acc_q;
    n_d    = n_q;
    zero_d = zero_q;
    case (state_q)
      IDLE: if (in_valid) begin
        ax_d = ax; ay_d = ay; az_d = az;
        bx_d = bx; by_d = by; bz_d = bz;
        state_d = SUB;
      end
      SUB: begin
        dx_d  = DW'(ax_q) - DW'(bx_q);
        dy_d  = DW'(ay_q) - DW'(by_q);
        dz_d  = DW'(az_q) - DW'(bz_q);
        acc_d = '0;
        state_d = MUL_X;
      end
      MUL_X: begin
        acc_d   = acc_q + ACC_W'($unsigned(sq));
        state_d = MUL_Y;
      end
      MUL_Y: begin
        acc_d   = acc_q + ACC_W'($unsigned(sq));
        state_d = MUL_Z;
      end
      MUL_Z: begin
        acc_d   = acc_q + ACC_W'($unsigned(sq));
        state_d = CONV;
      end
      CONV: begin
        if (acc_q == '0) begin
          n_d    = 32'h0;
          zero_d = 1'b1;
        end else begin
          n_d    = {1'b0, exp_f, frac_f};
          zero_d = 1'b0;
        end
        state_d = OUT;
      end
      OUT: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      ax_q <= '0; ay_q <= '0; az_q <= '0;
      bx_q <= '0; by_q <= '0; bz_q <= '0;
      dx_q <= '0; dy_q <= '0; dz_q <= '0;
      acc_q  <= '0;
      n_q    <= 32'h0;
      zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ax_q <= ax_d; ay_q <= ay_d; az_q <= az_d;
      bx_q <= bx_d; by_q <= by_d; bz_q <= bz_d;
      dx_q <= dx_d; dy_q <= dy_d; dz_q <= dz_d;
      acc_q  <= acc_d;
      n_q    <= n_d;
      zero_q <= zero_d;
    end
  end

endmodule

// File: tb/tb_dist_sq_to_float.sv
// Bench for dist_sq_to_float: vector table, handshake corner sequences, randomized model check.
module tb_dist_sq_to_float;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid, in_ready, out_valid, out_ready, zero;
  logic [15:0] ax, ay, az, bx, by, bz;
  logic [31:0] n;

  int checks = 0;
  int errors = 0;

  dist_sq_to_float #(.COORD_W(16)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .ax(ax), .ay(ay), .az(az), .bx(bx), .by(by), .bz(bz),
    .out_valid(out_valid), .out_ready(out_ready), .n(n), .zero(zero)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic signed [15:0] ax, ay, az, bx, by, bz;
    logic [31:0]        n;
    logic               z;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: squared distance as a plain integer, then float encoding by arithmetic.
  function automatic logic [31:0] model(input longint s);
    longint p, frac, man, rem, half, shv;
    if (s == 0) return 32'h0;
    p = 0;
    for (int i = 0; i < 40; i++)
      if (s >= (longint'(1) << i)) p = i;
    frac = s - (longint'(1) << p);
    if (p <= 23) begin
      man = frac << (23 - p);
    end else begin
      shv  = p - 23;
      man  = frac >> shv;
      rem  = frac - (man << shv);
      half = longint'(1) << (shv - 1);
`ifdef DIST_SQ_RNE_EN
      if (rem > half || (rem == half && man[0])) man = man + 1;
      if (man == (longint'(1) << 23)) begin
        man = 0;
        p   = p + 1;
      end
`endif
    end
    return {1'b0, 8'(127 + p), 23'(man)};
  endfunction

  function automatic longint dsq(input logic signed [15:0] a0, a1, a2, b0, b1, b2);
    longint x, y, z;
    x = longint'(a0) - longint'(b0);
    y = longint'(a1) - longint'(b1);
    z = longint'(a2) - longint'(b2);
    return x*x + y*y + z*z;
  endfunction

  // Presents one coordinate set and waits for out_valid; leaves the block in OUT.
  task automatic send(input logic signed [15:0] a0, a1, a2, b0, b1, b2,
                      output int lat, output logic busy_ok);
    int guard_cyc;
    guard_cyc = 0;
    while (!in_ready && guard_cyc < 30) begin
      @(posedge CLK); #1; guard_cyc++;
    end
    ax = a0; ay = a1; az = a2; bx = b0; by = b1; bz = b2;
    in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    lat = 1;
    busy_ok = 1'b1;
    if (in_ready) busy_ok = 1'b0;
    while (!out_valid && lat < 20) begin
      @(posedge CLK); #1;
      lat++;
      if (in_ready) busy_ok = 1'b0;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge CLK); #1;
  endtask

  vec_t        vecs[8];
  int          lat;
  logic        bok;
  logic [31:0] held;
  logic signed [15:0] r[6];

  initial begin
    vecs[0] = '{16'sd2, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 32'h40800000, 1'b0};
    vecs[1] = '{16'sd1, 16'sd1, 16'sd1, 16'sd0, 16'sd0, 16'sd0, 32'h40400000, 1'b0};
    vecs[2] = '{-16'sd5, 16'sd7, 16'sd3, -16'sd5, 16'sd7, 16'sd3, 32'h00000000, 1'b1};
`ifdef DIST_SQ_RNE_EN
    vecs[3] = '{16'sd4097, 16'sd1, 16'sd1, 16'sd0, 16'sd0, 16'sd0, 32'h4B801002, 1'b0};
`else
    vecs[3] = '{16'sd4097, 16'sd1, 16'sd1, 16'sd0, 16'sd0, 16'sd0, 32'h4B801001, 1'b0};
`endif
    vecs[4] = '{16'sd0, 16'sd3, 16'sd4, 16'sd0, 16'sd0, 16'sd0, 32'h41C80000, 1'b0};
    vecs[5] = '{16'sd1, 16'sd0, 16'sd0, 16'sd2, 16'sd0, 16'sd0, 32'h3F800000, 1'b0};
    vecs[6] = '{16'sd0, -16'sd3, 16'sd0, 16'sd0, 16'sd1, 16'sd0, 32'h41800000, 1'b0};
    vecs[7] = '{-16'sd100, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 32'h461C4000, 1'b0};

    RST = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    ax = '0; ay = '0; az = '0; bx = '0; by = '0; bz = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_n", n, 0);
    chk("rst_zero", zero, 0);
    RST = 1'b0;
    @(posedge CLK); #1;

    for (int i = 0; i < 8; i++) begin
      out_ready = 1'b1;
      send(vecs[i].ax, vecs[i].ay, vecs[i].az, vecs[i].bx, vecs[i].by, vecs[i].bz, lat, bok);
      chk($sformatf("vec%0d_latency", i), lat, 6);
      chk($sformatf("vec%0d_busy_ready", i), bok, 1);
      chk($sformatf("vec%0d_n", i), n, vecs[i].n);
      chk($sformatf("vec%0d_zero", i), zero, vecs[i].z);
      handshake();
      chk($sformatf("vec%0d_idle_after", i), {in_ready, out_valid}, 2'b10);
    end

    // Backpressure: result held for 10 cycles, pulsed input ignored.
    out_ready = 1'b0;
    send(16'sd2, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, lat, bok);
    held = n;
    chk("bp_first_n", held, 32'h40800000);
    bok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        ax = 16'd9; ay = 16'd9; az = 16'd9; bx = '0; by = '0; bz = '0;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge CLK); #1;
      if (!out_valid || in_ready || n !== held || zero) bok = 1'b0;
    end
    in_valid = 1'b0;
    chk("bp_held_stable", bok, 1);
    handshake();
    chk("bp_release_idle", {in_ready, out_valid}, 2'b10);
    chk("bp_n_kept", n, held);
    repeat (8) @(posedge CLK);
    #1;
    chk("bp_pulse_not_queued", {in_ready, out_valid}, 2'b10);

    // Reset during MUL_Y aborts without output.
    out_ready = 1'b1;
    ax = 16'd2; ay = '0; az = '0; bx = '0; by = '0; bz = '0;
    in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b1;
    #1;
    chk("abort_async", {in_ready, out_valid}, 2'b10);
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("abort_n_cleared", n, 0);
    send(16'sd0, 16'sd3, 16'sd4, 16'sd0, 16'sd0, 16'sd0, lat, bok);
    chk("abort_next_latency", lat, 6);
    chk("abort_next_n", n, 32'h41C80000);
    handshake();

    // Extreme corners.
    send(16'sd32767, 16'sd32767, 16'sd32767, -16'sd32768, -16'sd32768, -16'sd32768, lat, bok);
    chk("ext_valid", out_valid, 1);
    chk("ext_exp", n[30:23], 8'd160);
    chk("ext_sign", n[31], 0);
    chk("ext_model", n, model(dsq(16'sd32767, 16'sd32767, 16'sd32767,
                                  -16'sd32768, -16'sd32768, -16'sd32768)));
    handshake();

    // Randomized against the reference model, mixing small and full-range coordinates.
    for (int k = 0; k < 40; k++) begin
      for (int j = 0; j < 6; j++) begin
        if (k % 3 == 0) r[j] = 16'($signed($urandom_range(0, 400)) - 200);
        else            r[j] = 16'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      send(r[0], r[1], r[2], r[3], r[4], r[5], lat, bok);
      chk($sformatf("rnd%0d_n", k), n, model(dsq(r[0], r[1], r[2], r[3], r[4], r[5])));
      chk($sformatf("rnd%0d_zero", k), zero, (dsq(r[0], r[1], r[2], r[3], r[4], r[5]) == 0));
      repeat ($urandom_range(0, 2)) @(posedge CLK);
      #0;
      handshake();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
